// File: rtl/enemy_fire_scheduler_if.sv
// enemy_fire_scheduler_if
//   Groups the enemy AI / game FSM controls, the bullet slot array signals
//   and the player status outputs of enemy_fire_scheduler.
//
//   Controls (master -> slave): run, round_start, fire_req, burst_en, defend
//   Slot array (master -> slave): slot_busy, slot_hit
//   Results (slave -> master): slot_attack, fire_ack, busy, hp, hit_count,
//                              player_dead
//
//   Handshake: fire_req is a level request, not a strict valid/ready pair.
//   fire_ack pulses high for exactly one cycle, together with a one-hot
//   slot_attack, in each cycle a shot is really launched. A request can be
//   consumed without an ack (defend aborts the launch), so the requester
//   keeps fire_req high until it sees fire_ack if it still wants to shoot.
interface enemy_fire_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 run;
    logic                 round_start;
    logic                 fire_req;
    logic                 burst_en;
    logic                 defend;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic [NUM_SLOTS-1:0] slot_hit;
    logic [NUM_SLOTS-1:0] slot_attack;
    logic                 fire_ack;
    logic                 busy;
    logic [3:0]           hp;
    logic [7:0]           hit_count;
    logic                 player_dead;

    modport master (
        output run, round_start, fire_req, burst_en, defend, slot_busy, slot_hit,
        input  slot_attack, fire_ack, busy, hp, hit_count, player_dead
    );

    modport slave (
        input  run, round_start, fire_req, burst_en, defend, slot_busy, slot_hit,
        output slot_attack, fire_ack, busy, hp, hit_count, player_dead
    );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler
//   Shares NUM_SLOTS enemy bullet slots: turns fire requests into one-hot
//   launch pulses with round-robin slot choice, bursts, cooldown and defend
//   gating, and accumulates slot hits into player HP / hit count.
//
//   Ports: clk        frame clock
//          rst_n      asynchronous active-low reset
//          bus        enemy_fire_scheduler_if slave (controls, slots, status)
//          dbg_state  current scheduler state (0 IDLE, 1 FIRE, 2 GAP, 3 COOL)
module enemy_fire_scheduler #(
    parameter int NUM_SLOTS      = 4,
    parameter int COOLDOWN_TICKS = 30,
    parameter int BURST_LEN      = 3,
    parameter int BURST_GAP      = 6,
    parameter int MAX_HP         = 10,
    parameter int HIT_DMG        = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    enemy_fire_scheduler_if.slave        bus,
    output logic [1:0]                   dbg_state
);
    localparam int IW          = $clog2(NUM_SLOTS);
    localparam int MAX_SPACING = (COOLDOWN_TICKS > BURST_GAP) ? COOLDOWN_TICKS : BURST_GAP;
    localparam int CW          = ($clog2(MAX_SPACING) > 5) ? $clog2(MAX_SPACING) : 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]    shots_left_q, shots_left_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hp_q, hp_d;
    logic [7:0]    hit_count_q, hit_count_d;

    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          player_dead;
    logic          launch;
    logic [3:0]    hit_n;
    logic [7:0]    dmg;
    logic [7:0]    hp_wide;
    logic [8:0]    hit_sum;

    assign player_dead = (hp_q == 4'd0);

    // The launch is the FIRE cycle unless something in this very cycle
    // vetoes it; round_start also vetoes so rr_ptr stays consistent with
    // the restart.
    assign launch = (state_q == FIRE) && bus.run && !bus.round_start
                    && !player_dead && !bus.defend;

    // First free slot at or after rr_ptr, wrapping modulo NUM_SLOTS.
    always_comb begin
        logic [IW-1:0] idx;
        idx        = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = IW'((int'(rr_ptr_q) + k) % NUM_SLOTS);
            if (!free_found && !bus.slot_busy[idx]) begin
                free_found = 1'b1;
                free_idx   = idx;
            end
        end
    end

    // Hit accounting runs every cycle, independent of run and state.
    always_comb begin
        hit_n = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            hit_n = hit_n + {3'b000, bus.slot_hit[k]};
        end
        dmg     = 8'(hit_n) * 8'(HIT_DMG);
        hp_wide = {4'b0000, hp_q};
        hit_sum = {1'b0, hit_count_q} + {5'b00000, hit_n};
        if (bus.round_start) begin
            hp_d        = 4'(MAX_HP);
            hit_count_d = '0;
        end else begin
            hp_d        = (hp_wide > dmg) ? 4'(hp_wide - dmg) : 4'd0;
            hit_count_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        shots_left_d = shots_left_q;
        cnt_d        = cnt_q;
        if (bus.round_start) begin
            state_d      = IDLE;
            rr_ptr_d     = '0;
            cnt_d        = '0;
            shots_left_d = '0;
        end else if (!bus.run) begin
            // frozen: keep everything
        end else if (player_dead) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.fire_req && free_found) begin
                        grant_d      = free_idx;
                        shots_left_d = bus.burst_en ? 4'(BURST_LEN) : 4'd1;
                        state_d      = FIRE;
                    end
                end
                FIRE: begin
                    if (bus.defend) begin
                        state_d = IDLE;
                    end else begin
                        rr_ptr_d     = (grant_q == IW'(NUM_SLOTS - 1)) ? '0 : grant_q + 1'b1;
                        shots_left_d = shots_left_q - 4'd1;
                        if (shots_left_q == 4'd1) begin
                            state_d = COOL;
                            cnt_d   = CW'(COOLDOWN_TICKS - 2);
                        end else begin
                            state_d = GAP;
                            cnt_d   = CW'(BURST_GAP - 2);
                        end
                    end
                end
                GAP: begin
                    // A stall at cnt == 0 waits for any slot to free up.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (free_found) begin
                        grant_d = free_idx;
                        state_d = FIRE;
                    end
                end
                COOL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            shots_left_q <= '0;
            cnt_q        <= '0;
            hp_q         <= 4'(MAX_HP);
            hit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            shots_left_q <= shots_left_d;
            cnt_q        <= cnt_d;
            hp_q         <= hp_d;
            hit_count_q  <= hit_count_d;
        end
    end

    assign bus.slot_attack = launch ? (NUM_SLOTS'(1) << grant_q) : '0;
    assign bus.fire_ack    = launch;
    assign bus.busy        = (state_q != IDLE);
    assign bus.hp          = hp_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.player_dead = player_dead;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// tb_enemy_fire_scheduler
//   Directed scenarios (launch timing scoreboard, damage vector table,
//   saturation, freeze, asynchronous reset) plus randomized stimulus, all
//   cross-checked every cycle against a timestamp-based reference model.
module tb_enemy_fire_scheduler;
    localparam int N   = 4;
    localparam int CD  = 8;
    localparam int BL  = 3;
    localparam int BG  = 4;
    localparam int MHP = 5;
    localparam int DMG = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    enemy_fire_scheduler_if #(.NUM_SLOTS(N)) bus ();

    enemy_fire_scheduler #(
        .NUM_SLOTS(N), .COOLDOWN_TICKS(CD), .BURST_LEN(BL),
        .BURST_GAP(BG), .MAX_HP(MHP), .HIT_DMG(DMG)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int         n_checks = 0;
    int         n_errs   = 0;
    int         cyc      = 0;
    bit         sb_on    = 1'b0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] ent(input int c, input logic [3:0] a);
        logic [15:0] r;
        r = {c[11:0], a};
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Timing is kept as absolute cycle deadlines: the next burst shot may be
    // searched for once cyc+1 reaches m_gap_end, a new request is accepted
    // once cyc reaches m_cool_end; frozen cycles push deadlines out by one.
    int m_hp, m_hits, m_slot, m_shots, m_rr, m_gap_end, m_cool_end;
    bit m_armed;

    function automatic int popcnt(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int k = 0; k < N; k++) r += int'(v[k]);
        return r;
    endfunction

    function automatic bit find_free(input logic [N-1:0] busy_v, input int rr, output int s);
        s = 0;
        for (int k = 0; k < N; k++) begin
            if (!busy_v[(rr + k) % N]) begin
                s = (rr + k) % N;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_hp = MHP; m_hits = 0; m_armed = 1'b0; m_slot = 0;
        m_shots = 0; m_rr = 0; m_gap_end = 0; m_cool_end = 0;
    endtask

    task automatic model_advance();
        int  n, s;
        bit  dead_now;
        dead_now = (m_hp == 0);
        n = popcnt(bus.slot_hit);
        if (bus.round_start) begin
            model_reset();
        end else begin
            m_hp   = (m_hp - n * DMG < 0) ? 0 : m_hp - n * DMG;
            m_hits = (m_hits + n > 255) ? 255 : m_hits + n;
            if (!bus.run) begin
                m_gap_end++;
                m_cool_end++;
            end else if (dead_now) begin
                m_armed = 1'b0; m_shots = 0; m_cool_end = 0;
            end else if (m_armed) begin
                m_armed = 1'b0;
                if (bus.defend) begin
                    m_shots = 0;
                end else begin
                    m_rr = (m_slot + 1) % N;
                    m_shots--;
                    if (m_shots == 0) m_cool_end = cyc + CD;
                    else              m_gap_end  = cyc + BG;
                end
            end else if (m_shots > 0) begin
                if (cyc + 1 >= m_gap_end && find_free(bus.slot_busy, m_rr, s)) begin
                    m_armed = 1'b1; m_slot = s;
                end
            end else if (cyc >= m_cool_end && bus.fire_req && find_free(bus.slot_busy, m_rr, s)) begin
                m_armed = 1'b1; m_slot = s;
                m_shots = bus.burst_en ? BL : 1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.run = 1'b1; bus.round_start = 1'b0; bus.fire_req = 1'b0;
        bus.burst_en = 1'b0; bus.defend = 1'b0;
        bus.slot_busy = '0; bus.slot_hit = '0;
    endtask

    // One frame: compare outputs mid-cycle against the model, advance the
    // model with this cycle's inputs, return just after the next rising edge.
    task automatic step();
        int ea, eb;
        bit dead, lau;
        @(negedge clk);
        dead = (m_hp == 0);
        lau  = m_armed && bus.run && !bus.round_start && !dead && !bus.defend;
        ea   = lau ? (1 << m_slot) : 0;
        eb   = (m_armed || m_shots > 0 || cyc < m_cool_end) ? 1 : 0;
        chk("slot_attack", int'(bus.slot_attack), ea);
        chk("fire_ack", int'(bus.fire_ack), int'(lau));
        chk("busy", int'(bus.busy), eb);
        chk("hp", int'(bus.hp), m_hp);
        chk("hit_count", int'(bus.hit_count), m_hits);
        chk("player_dead", int'(bus.player_dead), int'(dead));
        if (sb_on && (bus.slot_attack != '0 || bus.fire_ack)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL launch_sb at cycle %0d: got attack %b, expected no launch", cyc, bus.slot_attack);
            end else begin
                chk("launch_sb", int'(ent(cyc, bus.slot_attack)), int'(exp_q.pop_front()));
            end
        end
        model_advance();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must respond at once.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_slot_attack", int'(bus.slot_attack), 0);
        chk("rst_fire_ack", int'(bus.fire_ack), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_hp", int'(bus.hp), MHP);
        chk("rst_hit_count", int'(bus.hit_count), 0);
        chk("rst_player_dead", int'(bus.player_dead), 0);
        chk("rst_state", int'(dbg_state), 0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    // ---------------- damage vector table ----------------
    typedef struct {
        logic [3:0] hit;
        logic       rs;
        logic       fire;
        int         exp_hp;
        int         exp_hits;
        logic       exp_dead;
    } dmg_vec_t;

    dmg_vec_t dvec[9];

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b1;
        clear_inputs();
        model_reset();

        dvec[0] = '{4'b0000, 1'b0, 1'b0, 5, 0, 1'b0};
        dvec[1] = '{4'b0011, 1'b0, 1'b0, 3, 2, 1'b0};
        dvec[2] = '{4'b0000, 1'b0, 1'b0, 3, 2, 1'b0};
        dvec[3] = '{4'b1111, 1'b0, 1'b0, 0, 6, 1'b1};
        dvec[4] = '{4'b0000, 1'b0, 1'b1, 0, 6, 1'b1};
        dvec[5] = '{4'b0001, 1'b0, 1'b1, 0, 7, 1'b1};
        dvec[6] = '{4'b0000, 1'b1, 1'b0, 5, 0, 1'b0};
        dvec[7] = '{4'b0001, 1'b1, 1'b0, 5, 0, 1'b0};
        dvec[8] = '{4'b0000, 1'b0, 1'b0, 5, 0, 1'b0};

        #1;
        do_reset();

        // Single shots: launches every COOLDOWN_TICKS+1 cycles.
        sb_on = 1'b1;
        exp_q.push_back(ent(11, 4'b0001));
        exp_q.push_back(ent(20, 4'b0010));
        exp_q.push_back(ent(29, 4'b0100));
        while (cyc <= 31) begin
            bus.fire_req = (cyc >= 10);
            step();
        end
        sb_drained("single_drained");

        // Bursts: BURST_GAP spacing, cooldown between bursts.
        do_reset();
        exp_q.push_back(ent(11, 4'b0001));
        exp_q.push_back(ent(15, 4'b0010));
        exp_q.push_back(ent(19, 4'b0100));
        exp_q.push_back(ent(28, 4'b1000));
        exp_q.push_back(ent(32, 4'b0001));
        while (cyc <= 34) begin
            bus.burst_en = 1'b1;
            bus.fire_req = (cyc >= 10);
            step();
        end
        sb_drained("burst_drained");

        // Occupancy: skip busy slots, stall in GAP, search from grant+1.
        do_reset();
        exp_q.push_back(ent(3, 4'b1000));
        exp_q.push_back(ent(11, 4'b0001));
        exp_q.push_back(ent(15, 4'b0010));
        while (cyc <= 17) begin
            bus.burst_en = 1'b1;
            bus.fire_req = (cyc == 2);
            if (cyc < 4)        bus.slot_busy = 4'b0111;
            else if (cyc < 10)  bus.slot_busy = 4'b1111;
            else if (cyc == 10) bus.slot_busy = 4'b1110;
            else                bus.slot_busy = 4'b0000;
            step();
        end
        sb_drained("occupancy_drained");

        // Defend in FIRE aborts; request re-accepted next cycle.
        do_reset();
        exp_q.push_back(ent(5, 4'b0001));
        while (cyc <= 7) begin
            bus.fire_req = (cyc >= 2 && cyc <= 4);
            bus.defend   = (cyc == 3);
            step();
        end
        sb_drained("defend_drained");

        // Damage table, then hit_count saturation.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.slot_hit    = dvec[i].hit;
            bus.round_start = dvec[i].rs;
            bus.fire_req    = dvec[i].fire;
            step();
            chk("tbl_hp", int'(bus.hp), dvec[i].exp_hp);
            chk("tbl_hit_count", int'(bus.hit_count), dvec[i].exp_hits);
            chk("tbl_player_dead", int'(bus.player_dead), int'(dvec[i].exp_dead));
        end
        clear_inputs();
        for (int i = 0; i < 64; i++) begin
            bus.slot_hit = 4'b1111;
            step();
        end
        bus.slot_hit = '0;
        chk("sat_hit_count", int'(bus.hit_count), 255);
        chk("sat_hp", int'(bus.hp), 0);
        chk("sat_player_dead", int'(bus.player_dead), 1);
        sb_drained("dead_drained");

        // Freeze during GAP (cnt == 1) for 5 cycles, then reset mid-COOL.
        do_reset();
        exp_q.push_back(ent(3, 4'b0001));
        exp_q.push_back(ent(12, 4'b0010));
        exp_q.push_back(ent(16, 4'b0100));
        while (cyc <= 19) begin
            bus.burst_en = 1'b1;
            bus.fire_req = (cyc == 2);
            bus.run      = !(cyc >= 5 && cyc <= 9);
            bus.slot_hit = (cyc == 13) ? 4'b0100 : 4'b0000;
            step();
        end
        sb_drained("freeze_drained");
        chk("pre_reset_busy", int'(bus.busy), 1);
        chk("pre_reset_hp", int'(bus.hp), 4);
        do_reset();
        sb_on = 1'b0;

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bus.run         = ($urandom_range(0, 9) != 0);
            bus.round_start = ($urandom_range(0, 49) == 0);
            bus.fire_req    = ($urandom_range(0, 9) < 6);
            bus.burst_en    = 1'($urandom_range(0, 1));
            bus.defend      = ($urandom_range(0, 6) == 0);
            bus.slot_busy   = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) bus.slot_hit[k] = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/enemy_fire_scheduler.md
# enemy_fire_scheduler

Sequences and shares a pool of `NUM_SLOTS` enemy bullet instances. It turns the enemy AI's fire requests into one-hot per-slot attack pulses, using round-robin slot allocation, burst mode, cooldown and defend gating. It also accumulates bullet hits into the player's HP and the dead flag. It sits between the enemy AI / game FSM and the bullet slot array, one cycle per game frame.

## Interface
Parameters:
- `NUM_SLOTS`, default 4. Number of bullet slots, 2..8.
- `COOLDOWN_TICKS`, default 30. Shot-to-shot spacing after a single shot or burst end. Must be ≥2.
- `BURST_LEN`, default 3. Shots per burst, 1..15.
- `BURST_GAP`, default 6. Spacing between shots inside a burst. Must be ≥2.
- `MAX_HP`, default 10. Player HP reload value, 1..15. `hp` is 4 bits.
- `HIT_DMG`, default 1. HP lost per hit, 1..15.

Ports:
- `clk` in 1: frame clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: game running. Low freezes the scheduler.
- `round_start` in 1: one-cycle pulse that restarts the round.
- `fire_req` in 1: enemy AI wants to shoot (level).
- `burst_en` in 1: next accepted request fires a burst.
- `defend` in 1: enemy defending. Blocks a launch in that cycle.
- `slot_busy` in NUM_SLOTS: per-slot bullet-alive flag.
- `slot_hit` in NUM_SLOTS: per-slot hit pulse.
- `slot_attack` out NUM_SLOTS: one-hot launch pulse to the slots.
- `fire_ack` out 1: a shot was launched this cycle.
- `busy` out 1: scheduler is not IDLE.
- `hp` out 4: player HP.
- `hit_count` out 8: hits this round, saturates at 255.
- `player_dead` out 1: `hp == 0`.

## Operation
- States: IDLE, FIRE, GAP, COOL. Registers:
  - `grant` (slot index)
  - `rr_ptr` (slot index)
  - `shots_left` (4 bits)
  - `cnt` (5 bits minimum, sized to the max of the two spacing parameters)
- Free-slot search: start at `rr_ptr`, increment modulo `NUM_SLOTS`, take the first slot with `slot_busy == 0`.
- IDLE: when `run && fire_req && !player_dead` and a free slot exists:
  - latch `grant`;
  - set `shots_left = burst_en ? BURST_LEN : 1`;
  - go to FIRE.
  - Otherwise stay in IDLE.
- FIRE (one cycle): `slot_attack = onehot(grant) & {NUM_SLOTS{!defend}}`, and `fire_ack = !defend`. `slot_attack` is combinational from state, `grant` and `defend`.
  - If `defend` is high: abort. Go to IDLE with `rr_ptr` and counters unchanged and no cooldown.
  - Otherwise: set `rr_ptr = (grant+1) mod NUM_SLOTS` and decrement `shots_left`.
    - If the new `shots_left` is 0: go to COOL with `cnt = COOLDOWN_TICKS-2`.
    - Else: go to GAP with `cnt = BURST_GAP-2`.
- GAP: decrement `cnt` while it is nonzero.
  - At `cnt == 0` with a free slot: latch `grant` and go to FIRE.
  - At `cnt == 0` with no free slot: hold in GAP.
  - `fire_req` and `burst_en` are ignored. `defend` only matters in FIRE.
- COOL: decrement `cnt`. At 0, go to IDLE. `fire_req` is ignored.
- `player_dead` going high in any state: return to IDLE on the next cycle without launching.
- `run` low: state, `cnt`, `grant` and `rr_ptr` are frozen, and `slot_attack` and `fire_ack` are forced to 0. Hit accounting continues.
- Hit accounting, every cycle:
  - `n = popcount(slot_hit)`.
  - `hp <= (hp > n*HIT_DMG) ? hp - n*HIT_DMG : 0`, computed at ≥8-bit width with no wrap.
  - `hit_count <= min(hit_count + n, 255)`.
- `round_start` has priority over everything in its cycle. Next cycle:
  - state IDLE, `rr_ptr = 0`, `cnt = 0`;
  - `hp = MAX_HP`, `hit_count = 0`;
  - that cycle's hits are discarded.
- Only busy-to-free transitions of `slot_busy` come from the slots, so a slot free at grant time is still free in FIRE.

## Timing
- Reset values: state IDLE, `grant = 0`, `rr_ptr = 0`, `cnt = 0`, `shots_left = 0`.
  - `slot_attack = 0`, `fire_ack = 0`, `busy = 0`.
  - `hp = MAX_HP`, `hit_count = 0`, `player_dead = 0`.
- An asynchronous reset mid-burst or mid-cooldown returns to these values immediately.
- Accepted request in IDLE at cycle n gives the launch (`slot_attack`, `fire_ack`) at n+1. The slot's `slot_busy` rises at n+2.
- In a burst, launches are exactly `BURST_GAP` cycles apart when slots are free. A stall at `cnt == 0` adds cycles one-for-one.
- After the last launch at cycle t, IDLE is reached at t+`COOLDOWN_TICKS`. The earliest next launch is t+`COOLDOWN_TICKS`+1.
- `hp`, `hit_count` and `player_dead` update on the cycle after `slot_hit`.
- `busy` is registered state and is 1 in FIRE, GAP and COOL.

## Test plan
All scenarios use NUM_SLOTS=4, COOLDOWN_TICKS=8, BURST_LEN=3, BURST_GAP=4, MAX_HP=5, HIT_DMG=1.
- Single shots: all slots free, `fire_req` held from cycle 10, `burst_en = 0` -> `slot_attack` 0001 at 11, 0010 at 20, 0100 at 29, with `fire_ack` coincident.
- Burst: `burst_en = 1`, `fire_req` from cycle 10 -> 0001 at 11, 0010 at 15, 0100 at 19. Next burst starts at 28 with 1000, then 0001 at 32.
- Occupancy: `slot_busy = 0111` with `rr_ptr = 0` -> grant 1000. Then all busy during GAP -> no pulse until a slot frees at cycle k, launch at k+1. After this launch, the free-slot search starts at slot 1 (`(grant+1) mod 4`).
- Defend: `defend = 1` in the FIRE cycle -> `slot_attack = 0000`, `fire_ack = 0`, IDLE next cycle, `rr_ptr` unchanged. The request is re-accepted the following cycle.
- Damage: `slot_hit = 0011` for one cycle -> `hp` 3, `hit_count` 2. Then `slot_hit = 1111` -> `hp` 0, `hit_count` 6, `player_dead = 1`, and `fire_req` is ignored. `round_start` -> `hp` 5, `hit_count` 0, `player_dead = 0`.
- Freeze and reset: drop `run` during GAP with `cnt = 1` for 5 cycles -> no pulse, spacing extended by 5. Assert `rst_n` low mid-COOL -> all outputs take their reset values asynchronously.
